eviction_write_buffer: RTL and testbench
========================================

Name: eviction_write_buffer

Overview:
- Victim/eviction write buffer between the cache-side arbiter (upstream) and the 256-bit cacheline adapter (downstream).
- Absorbs dirty-line write-backs in one cycle and drains them to memory when the memory side is idle.
- Services upstream reads from buffered lines, or forwards them to memory, so a read never waits behind a write-back it does not depend on.

Parameters:
- DEPTH, 4, number of buffered lines; legal 1..8.
- BYPASS, 1'b0, when 1 the block is a registered pass-through with no storage; this is the enable_ewb=0 build.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_read  input  1  upstream line read; held until req_resp
- req_write  input  1  upstream line write (eviction); held until req_resp
- req_addr  input  32  line address; bits [4:0] ignored
- req_wdata  input  256  eviction line data
- req_rdata  output  256  read line data; valid when req_resp=1
- req_resp  output  1  one-cycle completion pulse
- mem_read  output  1  to cacheline adapter; held until mem_resp
- mem_write  output  1  to cacheline adapter; held until mem_resp
- mem_addr  output  32  line-aligned address; [4:0]=0
- mem_wdata  output  256  line to write
- mem_rdata  input  256  line from adapter
- mem_resp  input  1  adapter completion pulse
- ewb_count  output  $clog2(DEPTH+1)  occupied entries, for performance counters

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs are 0; ewb_count=0.
  - FIFO head and tail pointers are 0; all valid bits are cleared; state is IDLE.
  - Buffered lines are discarded.
  - Reset during DRAIN or READ_MISS aborts the transaction with no completion; the adapter is reset by the same reset.
- Storage:
  - Circular FIFO of DEPTH entries {valid, tag[31:5], line[255:0]}.
  - Pointers wrap modulo DEPTH.
- Match:
  - Compare req_addr[31:5] against every valid tag.
  - Duplicate tags cannot exist because writes coalesce, so at most one entry matches.
- States: IDLE, DRAIN, READ_MISS, RESP.
- IDLE, evaluated in priority order:
  1. req_read with a buffer hit: load req_rdata from the matching entry; go to RESP. Latency is request cycle N to req_resp at N+1.
  2. req_read with a miss: drive mem_read=1 and mem_addr={req_addr[31:5],5'b0}; go to READ_MISS.
  3. req_write with a hit: overwrite that entry's line in place (coalesce); count is unchanged; go to RESP.
  4. req_write with a miss and not full: push at tail; count+1; go to RESP.
  5. req_write with a miss and full: start draining the head; the write is not accepted. It is accepted in the first IDLE cycle after the drain completes.
  6. No request and count>0: drive mem_write=1 with the head entry's address and line; go to DRAIN.
  7. Otherwise: stay in IDLE.
- READ_MISS:
  - Hold mem_read and mem_addr.
  - On mem_resp: latch mem_rdata into req_rdata; deassert mem_read; go to RESP.
  - Latency is mem_resp cycle M to req_resp at M+1.
- DRAIN:
  - Hold mem_write, mem_addr and mem_wdata stable.
  - On mem_resp: invalidate the head; head+1; count-1; deassert mem_write; go to IDLE.
  - A drain is never aborted. Upstream requests arriving during DRAIN wait; they are not accepted and receive no resp.
- RESP:
  - req_resp=1 for exactly one cycle; then go to IDLE.
  - Requests are ignored in the RESP cycle, because the requester deasserts on the cycle after it sees resp.
- Ordering: drains go strictly oldest-first.
- Read-after-write coherence is guaranteed because:
  - reads check the buffer before memory;
  - a line leaves the buffer only after memory has acknowledged it.
- mem_read and mem_write are never asserted together.
- req_read and req_write asserted together is illegal. Add an assertion for it; read wins.
- BYPASS=1:
  - Requests are forwarded to mem_* in the cycle after acceptance.
  - mem_resp and mem_rdata are registered into req_resp and req_rdata.
  - ewb_count is always 0.

Decomposition:
- Shared package rv32i_types:
  - cacheline_t (logic [255:0]) and line_tag_t (logic [26:0]).
  - ewb_state_t enum {IDLE, DRAIN, READ_MISS, RESP}.
- Sub-module ewb_match:
  - Combinational tag CAM.
  - Inputs: tags, valid bits, query tag.
  - Outputs: hit and a one-hot or encoded index.
- FIFO storage and the FSM stay in eviction_write_buffer.

Test Plan:
1. Write 0x0000_1040 with line A -> req_resp at N+1; ewb_count=1. Then read 0x0000_1044 -> req_rdata=A at N+1 with no mem_read.
2. Four writes to distinct lines with the bench holding mem_resp low -> ewb_count=4. A 5th write produces mem_write to the oldest address. Give mem_resp after 8 cycles -> the 5th write gets req_resp 2 cycles later; ewb_count=4.
3. Write 0x2000 with line B, then write 0x2000 with line C -> ewb_count=1. The idle drain issues mem_wdata=C exactly once.
4. Read 0x3000, which is not buffered -> mem_read=1 with mem_addr=0x3000 the next cycle. Give mem_resp with line D -> req_rdata=D and req_resp one cycle later.
5. Buffer lines at 0x100, 0x200 and 0x300 -> idle drains appear with mem_addr=0x100, then 0x200, then 0x300; ewb_count decrements on each mem_resp.
6. Assert reset_n=0 mid-DRAIN -> all outputs 0 immediately and ewb_count=0. After release, a read of the drained address goes to memory.

Source files
------------

// File: rtl/eviction_write_buffer_pkg.sv
// Shared types for the eviction write buffer.
//   cacheline_t : one 256-bit cache line
//   line_tag_t  : line address bits [31:5]
//   ewb_state_t : buffer controller states
package rv32i_types;

    typedef logic [255:0] cacheline_t;
    typedef logic [26:0]  line_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        READ_MISS,
        RESP
    } ewb_state_t;

endpackage

// File: rtl/ewb_match.sv
// Combinational tag CAM for the eviction write buffer.
// Ports:
//   i_tags  : tag of every entry
//   i_valid : valid bit of every entry
//   i_qtag  : query tag (request address [31:5])
//   o_hit   : some valid entry holds i_qtag
//   o_idx   : encoded index of that entry (0 when no hit)
// Writes coalesce, so at most one entry can match.
module ewb_match
    import rv32i_types::*;
#(
    parameter  int DEPTH = 4,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  line_tag_t [DEPTH-1:0] i_tags,
    input  logic      [DEPTH-1:0] i_valid,
    input  line_tag_t             i_qtag,
    output logic                  o_hit,
    output logic      [IW-1:0]    o_idx
);

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_valid[i] && (i_tags[i] == i_qtag)) begin
                o_hit = 1'b1;
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/eviction_write_buffer.sv
// Victim/eviction write buffer between the cache-side arbiter and the
// 256-bit cacheline adapter. Dirty lines are absorbed in one cycle into a
// circular FIFO and drained oldest-first while the upstream is quiet.
// Reads are served from the buffer on a hit, otherwise forwarded to memory.
// Ports:
//   clk, reset_n                     : clock, async active-low reset
//   req_read/req_write/req_addr/
//   req_wdata/req_rdata/req_resp     : upstream line interface
//   mem_read/mem_write/mem_addr/
//   mem_wdata/mem_rdata/mem_resp     : cacheline adapter interface
//   ewb_count                        : occupied entries
// BYPASS=1 gives a registered pass-through with no storage.
module eviction_write_buffer
    import rv32i_types::*;
#(
    parameter  int DEPTH  = 4,
    parameter  bit BYPASS = 1'b0,
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_read,
    input  logic          req_write,
    input  logic [31:0]   req_addr,
    input  logic [255:0]  req_wdata,
    output logic [255:0]  req_rdata,
    output logic          req_resp,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_addr,
    output logic [255:0]  mem_wdata,
    input  logic [255:0]  mem_rdata,
    input  logic          mem_resp,
    output logic [CW-1:0] ewb_count
);

    ewb_state_t            r_state, w_next_state;
    logic      [IW-1:0]    r_head, r_tail;
    logic      [CW-1:0]    r_count;
    logic      [DEPTH-1:0] r_valid;
    line_tag_t [DEPTH-1:0] r_tag;
    cacheline_t [DEPTH-1:0] r_line;
    cacheline_t            r_rdata;
    logic                  r_mem_read, r_mem_write;
    logic      [31:0]      r_mem_addr;
    cacheline_t            r_mem_wdata;

    line_tag_t             w_qtag;
    logic                  w_hit, w_full;
    logic      [IW-1:0]    w_hit_idx;
    logic                  w_ld_hit, w_ld_mem, w_push, w_coalesce, w_pop;
    logic                  w_start_read, w_start_drain, w_start_bwrite, w_mem_done;
    logic                  w_unused;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_qtag   = req_addr[31:5];
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_unused = ^req_addr[4:0];

    ewb_match #(.DEPTH(DEPTH)) u_match (
        .i_tags  (r_tag),
        .i_valid (r_valid),
        .i_qtag  (w_qtag),
        .o_hit   (w_hit),
        .o_idx   (w_hit_idx)
    );

    always_comb begin
        w_next_state   = r_state;
        w_ld_hit       = 1'b0;
        w_ld_mem       = 1'b0;
        w_push         = 1'b0;
        w_coalesce     = 1'b0;
        w_pop          = 1'b0;
        w_start_read   = 1'b0;
        w_start_drain  = 1'b0;
        w_start_bwrite = 1'b0;
        w_mem_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (BYPASS) begin
                    if (req_read) begin
                        w_start_read = 1'b1;
                        w_next_state = READ_MISS;
                    end else if (req_write) begin
                        w_start_bwrite = 1'b1;
                        w_next_state   = DRAIN;
                    end
                end else if (req_read && w_hit) begin
                    w_ld_hit     = 1'b1;
                    w_next_state = RESP;
                end else if (req_read) begin
                    w_start_read = 1'b1;
                    w_next_state = READ_MISS;
                end else if (req_write && w_hit) begin
                    w_coalesce   = 1'b1;
                    w_next_state = RESP;
                end else if (req_write && !w_full) begin
                    w_push       = 1'b1;
                    w_next_state = RESP;
                end else if (r_count != '0) begin
                    // Full-miss write or quiet upstream: drain the oldest line.
                    // A stalled write is retried in the IDLE after the drain.
                    w_start_drain = 1'b1;
                    w_next_state  = DRAIN;
                end
            end
            READ_MISS: begin
                if (mem_resp) begin
                    w_ld_mem     = 1'b1;
                    w_mem_done   = 1'b1;
                    w_next_state = RESP;
                end
            end
            DRAIN: begin
                if (mem_resp) begin
                    w_mem_done = 1'b1;
                    if (BYPASS) begin
                        w_ld_mem     = 1'b1;
                        w_next_state = RESP;
                    end else begin
                        w_pop        = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_valid     <= '0;
            r_rdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ld_hit) r_rdata <= r_line[w_hit_idx];
            if (w_ld_mem) r_rdata <= mem_rdata;
            if (w_mem_done) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
            if (w_start_read) begin
                r_mem_read <= 1'b1;
                r_mem_addr <= {req_addr[31:5], 5'b0};
            end
            if (w_start_bwrite) begin
                r_mem_write <= 1'b1;
                r_mem_addr  <= {req_addr[31:5], 5'b0};
                r_mem_wdata <= req_wdata;
            end
            if (w_start_drain) begin
                r_mem_write <= 1'b1;
                r_mem_addr  <= {r_tag[r_head], 5'b0};
                r_mem_wdata <= r_line[r_head];
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= ptr_inc(r_tail);
                r_count         <= r_count + 1'b1;
            end
            // The head leaves only once memory has acknowledged it.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ptr_inc(r_head);
                r_count         <= r_count - 1'b1;
            end
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_tail]  <= w_qtag;
            r_line[r_tail] <= req_wdata;
        end
        if (w_coalesce) r_line[w_hit_idx] <= req_wdata;
    end

    assign req_rdata = r_rdata;
    assign req_resp  = (r_state == RESP);
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ewb_count = r_count;

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(req_read && req_write));

endmodule

// File: tb/tb_eviction_write_buffer.sv
module tb_eviction_write_buffer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_read = 1'b0, req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic [255:0] req_rdata;
    logic         req_resp;
    logic         mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;
    logic [2:0]   ewb_count;

    always #5 clk = ~clk;

    eviction_write_buffer #(.DEPTH(4), .BYPASS(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rdata(req_rdata), .req_resp(req_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .ewb_count(ewb_count)
    );

    typedef struct { bit is_rd; logic [255:0] data; } resp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } memtx_t;

    resp_t  exp_resp[$];
    memtx_t exp_mem[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int mem_lat = 2;
    logic [255:0] mem_line = '0;
    int mem_seen_cyc = 0, mem_resp_cyc = 0, issue_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [255:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h required=none", name, act);
    endtask

    task automatic push_mem(input bit wr, input logic [31:0] addr, input logic [255:0] d);
        memtx_t m;
        m.wr = wr; m.addr = addr; m.data = d;
        exp_mem.push_back(m);
    endtask

    // Issue one request, hold it until req_resp, return cycles waited.
    task automatic do_req(input bit rd, input logic [31:0] addr, input logic [255:0] d, output int lat);
        resp_t e;
        e.is_rd = rd; e.data = d;
        exp_resp.push_back(e);
        req_read = rd; req_write = !rd; req_addr = addr; req_wdata = d;
        issue_cyc = cyc;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (req_resp) break;
            if (lat > 100) begin note_fail("req_timeout", addr); break; end
        end
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic wait_count(input string name, input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ewb_count == 3'(target)) break;
        end
        chk(name, ewb_count, target);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_req_resp"}, req_resp, 0);
        chk({p, "_req_rdata"}, req_rdata, 0);
        chk({p, "_mem_read"}, mem_read, 0);
        chk({p, "_mem_write"}, mem_write, 0);
        chk({p, "_mem_addr"}, mem_addr, 0);
        chk({p, "_mem_wdata"}, mem_wdata, 0);
        chk({p, "_ewb_count"}, ewb_count, 0);
    endtask

    // Upstream response monitor.
    always @(negedge clk) begin
        resp_t e;
        if (reset_n && req_resp) begin
            if (exp_resp.size() == 0) note_fail("unexpected_resp", req_rdata);
            else begin
                e = exp_resp.pop_front();
                if (e.is_rd) chk("req_rdata", req_rdata, e.data);
            end
        end
    end

    // Memory model and memory-side monitor.
    initial begin
        memtx_t m;
        bit aborted;
        forever begin
            @(negedge clk);
            if (reset_n && (mem_read || mem_write)) begin
                mem_seen_cyc = cyc;
                chk("mem_rd_wr_excl", mem_read & mem_write, 0);
                if (exp_mem.size() == 0) note_fail("unexpected_mem_tx", {mem_write, mem_addr});
                else begin
                    m = exp_mem.pop_front();
                    chk("mem_op_write", mem_write, m.wr);
                    chk("mem_addr", mem_addr, m.addr);
                    if (m.wr) chk("mem_wdata", mem_wdata, m.data);
                end
                aborted = 1'b0;
                for (int k = 0; k < mem_lat; k++) begin
                    @(posedge clk); #1;
                    if (!reset_n) begin aborted = 1'b1; break; end
                end
                if (!aborted) begin
                    mem_resp = 1'b1;
                    mem_rdata = mem_line;
                    mem_resp_cyc = cyc;
                    @(posedge clk); #1;
                    mem_resp = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [255:0] la, lb, lc, ld, lg, lh;
        logic [255:0] l2 [5];
        la = {8{32'hA0A0_0001}}; lb = {8{32'hB0B0_0002}}; lc = {8{32'hC0C0_0003}};
        ld = {8{32'hD0D0_0004}}; lg = {8{32'h6060_0007}}; lh = {8{32'h7070_0008}};
        for (int i = 0; i < 5; i++) l2[i] = {8{32'h5500_0000 + 32'(i)}};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: write then read-hit
        push_mem(1'b1, 32'h0000_1040, la);
        do_req(1'b0, 32'h0000_1040, la, lat);
        chk("t1_wr_lat", lat, 1);
        chk("t1_count", ewb_count, 1);
        do_req(1'b1, 32'h0000_1044, la, lat);
        chk("t1_rd_lat", lat, 2);
        wait_count("t1_drained", 0);

        // 2: fill, then a full-miss write forces a drain of the oldest
        mem_lat = 8;
        for (int i = 0; i < 5; i++) push_mem(1'b1, 32'h0001_0000 + 32'(i * 32), l2[i]);
        for (int i = 0; i < 4; i++) do_req(1'b0, 32'h0001_0000 + 32'(i * 32), l2[i], lat);
        chk("t2_full_count", ewb_count, 4);
        do_req(1'b0, 32'h0001_0080, l2[4], lat);
        chk("t2_resp_after_drain", cyc, mem_resp_cyc + 2);
        chk("t2_count_after", ewb_count, 4);
        mem_lat = 2;
        wait_count("t2_drained", 0);

        // 3: coalescing
        push_mem(1'b1, 32'h0000_2000, lc);
        do_req(1'b0, 32'h0000_2000, lb, lat);
        do_req(1'b0, 32'h0000_2000, lc, lat);
        chk("t3_count", ewb_count, 1);
        wait_count("t3_drained", 0);
        repeat (10) @(negedge clk);

        // 4: read miss
        push_mem(1'b0, 32'h0000_3000, '0);
        mem_line = ld;
        do_req(1'b1, 32'h0000_3000, ld, lat);
        chk("t4_memread_next_cycle", mem_seen_cyc, issue_cyc + 1);
        chk("t4_resp_lat", cyc, mem_resp_cyc + 1);

        // 5: oldest-first drain order
        mem_lat = 3;
        push_mem(1'b1, 32'h0000_0100, la);
        push_mem(1'b1, 32'h0000_0200, lb);
        push_mem(1'b1, 32'h0000_0300, lc);
        do_req(1'b0, 32'h0000_0100, la, lat);
        do_req(1'b0, 32'h0000_0200, lb, lat);
        do_req(1'b0, 32'h0000_0300, lc, lat);
        chk("t5_count3", ewb_count, 3);
        wait_count("t5_count2", 2);
        wait_count("t5_count1", 1);
        wait_count("t5_count0", 0);

        // 6: reset in the middle of a drain
        mem_lat = 50;
        push_mem(1'b1, 32'h0000_0400, lg);
        do_req(1'b0, 32'h0000_0400, lg, lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_write) break;
        end
        chk("t6_in_drain", mem_write, 1);
        #2 reset_n = 1'b0;
        #1 chk_zero("t6_rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        mem_lat = 2;
        push_mem(1'b0, 32'h0000_0400, '0);
        mem_line = lh;
        @(posedge clk); #1;
        do_req(1'b1, 32'h0000_0400, lh, lat);
        chk("t6_count", ewb_count, 0);

        repeat (10) @(posedge clk);
        chk("exp_mem_left", exp_mem.size(), 0);
        chk("exp_resp_left", exp_resp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
